// File: rtl/qed_dup_issue.sv
// qed_dup_issue
//   Sits between the vscale instruction memory and the decode stage and turns
//   the fetched stream into a QED test sequence.
//   - Originals use only x0..x15; they are forwarded and recorded in a buffer.
//   - On exec_dup, or when the buffer fills, the recorded instructions are replayed
//     with their register fields moved to x16..x31.
//   - The pipeline is then drained with NOPs, and a one-cycle chk_en strobe is
//     raised so the register-match checker can compare x1..x15 with x17..x31.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   imem_rdata/vld    fetched instruction and its valid flag
//   imem_rdy          block accepts imem_rdata this cycle
//   exec_dup          request to start the duplicate phase (honoured only in ORIG)
//   pipe_rdy          decode consumes qed_instr this cycle
//   qed_instr/vld     instruction presented to decode
//   wait_till_commit  high while draining and checking
//   chk_en            one-cycle register-match strobe
//   num_orig_insts    originals buffered in the current sequence
//   num_dup_insts     duplicates issued in the current sequence
module qed_dup_issue #(
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_vld,
    output logic          imem_rdy,
    input  logic          exec_dup,
    input  logic          pipe_rdy,
    output logic [31:0]   qed_instr,
    output logic          qed_vld,
    output logic          wait_till_commit,
    output logic          chk_en,
    output logic [CW-1:0] num_orig_insts,
    output logic [CW-1:0] num_dup_insts
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          DW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_IALU = 7'b0010011;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;

    typedef enum logic [1:0] {ORIG, DUP, DRAIN, CHECK} state_t;

    state_t          state, state_nxt;
    logic [31:0]     buffer [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [DW-1:0]   drain_cnt;
    logic [31:0]     orig_instr;
    logic            orig_legal;
    logic            buf_wr;
    logic            dup_take;
    logic            drain_take;

    // Register fields present for an opcode, as {rs2, rs1, rd}; zero means the
    // instruction is outside the supported classes and becomes a NOP.
    function automatic logic [2:0] reg_fields(input logic [6:0] opcode);
        case (opcode)
            OP_R:    return 3'b111;
            OP_IALU: return 3'b011;
            OP_LUI:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Original form: bit 4 of each register field cleared (x0..x15 only).
    function automatic logic [31:0] to_orig(input logic [31:0] instr);
        logic [2:0]  f;
        logic [31:0] r;
        f = reg_fields(instr[6:0]);
        r = instr;
        if (f == 3'b000) r = NOP;
        if (f[0]) r[11] = 1'b0;
        if (f[1]) r[19] = 1'b0;
        if (f[2]) r[24] = 1'b0;
        return r;
    endfunction

    // Duplicate form: bit 4 set on every nonzero register field so x0 stays x0.
    function automatic logic [31:0] to_dup(input logic [31:0] o);
        logic [2:0]  f;
        logic [31:0] r;
        f = reg_fields(o[6:0]);
        r = o;
        if (f[0] && (o[10:7]  != 4'd0)) r[11] = 1'b1;
        if (f[1] && (o[18:15] != 4'd0)) r[19] = 1'b1;
        if (f[2] && (o[23:20] != 4'd0)) r[24] = 1'b1;
        return r;
    endfunction

    assign orig_instr = to_orig(imem_rdata);
    assign orig_legal = (reg_fields(imem_rdata[6:0]) != 3'b000);

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt        = state;
        imem_rdy         = 1'b0;
        qed_vld          = 1'b0;
        qed_instr        = NOP;
        wait_till_commit = 1'b0;
        chk_en           = 1'b0;
        buf_wr           = 1'b0;
        dup_take         = 1'b0;
        drain_take       = 1'b0;
        if (!rst) begin
            case (state)
                ORIG: begin
                    imem_rdy  = pipe_rdy && (num_orig_insts < CW'(DEPTH));
                    qed_vld   = imem_vld && imem_rdy;
                    qed_instr = orig_instr;
                    buf_wr    = qed_vld && orig_legal;
                    // The transfer of this cycle counts toward both exits.
                    if (pipe_rdy) begin
                        if (buf_wr && (num_orig_insts == CW'(DEPTH - 1)))
                            state_nxt = DUP;
                        else if (exec_dup && (buf_wr || (num_orig_insts != '0)))
                            state_nxt = DUP;
                    end
                end
                DUP: begin
                    qed_vld   = 1'b1;
                    qed_instr = to_dup(buffer[head]);
                    dup_take  = pipe_rdy;
                    // Count-based "last entry" test; a full buffer has head == tail.
                    if (pipe_rdy && ((num_dup_insts + CW'(1)) == num_orig_insts))
                        state_nxt = DRAIN;
                end
                DRAIN: begin
                    qed_vld          = 1'b1;
                    wait_till_commit = 1'b1;
                    drain_take       = pipe_rdy;
                    if (pipe_rdy && (drain_cnt == '0))
                        state_nxt = CHECK;
                end
                CHECK: begin
                    chk_en           = 1'b1;
                    wait_till_commit = 1'b1;
                    state_nxt        = ORIG;
                end
                default: state_nxt = ORIG;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ORIG;
            head           <= '0;
            tail           <= '0;
            num_orig_insts <= '0;
            num_dup_insts  <= '0;
            drain_cnt      <= '0;
            // NOTE: the buffer is cleared on reset so a replay can never expose
            // stale instructions from an abandoned sequence.
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        end else begin
            state <= state_nxt;
            if (buf_wr) begin
                buffer[tail]   <= orig_instr;
                tail           <= tail + PW'(1);
                num_orig_insts <= num_orig_insts + CW'(1);
            end
            if (dup_take) begin
                head          <= head + PW'(1);
                num_dup_insts <= num_dup_insts + CW'(1);
            end
            if ((state == DUP) && (state_nxt == DRAIN))
                drain_cnt <= DW'(DRAIN_CYCLES - 1);
            else if (drain_take && (drain_cnt != '0))
                drain_cnt <= drain_cnt - DW'(1);
            if (state == CHECK) begin
                head           <= '0;
                tail           <= '0;
                num_orig_insts <= '0;
                num_dup_insts  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qed_dup_issue.sv
// Testbench for qed_dup_issue: random and directed QED sequences, checked by a
// scoreboard fed from a register-field-level reference model.
module tb_qed_dup_issue;

    localparam int          DEPTH        = 8;
    localparam int          DRAIN_CYCLES = 4;
    localparam int          CW           = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP          = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   imem_rdata;
    logic          imem_vld;
    logic          imem_rdy;
    logic          exec_dup;
    logic          pipe_rdy;
    logic [31:0]   qed_instr;
    logic          qed_vld;
    logic          wait_till_commit;
    logic          chk_en;
    logic [CW-1:0] num_orig_insts;
    logic [CW-1:0] num_dup_insts;

    qed_dup_issue #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_rdata       (imem_rdata),
        .imem_vld         (imem_vld),
        .imem_rdy         (imem_rdy),
        .exec_dup         (exec_dup),
        .pipe_rdy         (pipe_rdy),
        .qed_instr        (qed_instr),
        .qed_vld          (qed_vld),
        .wait_till_commit (wait_till_commit),
        .chk_en           (chk_en),
        .num_orig_insts   (num_orig_insts),
        .num_dup_insts    (num_dup_insts)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_chk;
        logic [31:0] val;     // instruction, or sequence length for a check strobe
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mbuf[$];     // model buffer of original forms
    int          checks    = 0;
    int          failures  = 0;
    int          chk_seen  = 0;
    bit          mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nfields(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return 3;
            7'h13:   return 2;
            7'h37:   return 1;
            default: return 0;
        endcase
    endfunction

    // Register numbers are rewritten arithmetically: originals use reg % 16,
    // duplicates add 16 to every nonzero register.
    function automatic logic [31:0] remap(input logic [31:0] ins, input bit dup);
        logic [31:0] r;
        int          lo[3];
        int          v;
        lo = '{7, 15, 20};
        r  = ins;
        if (nfields(ins) == 0) return NOP;
        for (int k = 0; k < nfields(ins); k++) begin
            v = int'((ins >> lo[k]) & 32'd31);
            v = v % 16;
            if (dup && v != 0) v = v + 16;
            r[lo[k] +: 5] = v[4:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ill[4];
        ill = '{7'h63, 7'h03, 7'h23, 7'h6F};
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       r[6:0] = 7'h33;
            1, 2:    r[6:0] = 7'h13;
            3:       r[6:0] = 7'h37;
            default: r[6:0] = ill[$urandom_range(0, 3)];
        endcase
        return r;
    endfunction

    // ---------------- monitor ----------------
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (mon_en && !rst) begin
            check("dup_le_orig", 32'(num_dup_insts <= num_orig_insts), 32'd1);
            if (qed_vld && pipe_rdy) begin
                check("exp_avail_xfer", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("kind_xfer", 32'(e.is_chk), 32'd0);
                    check("qed_instr", qed_instr, e.val);
                end
            end
            if (chk_en) begin
                chk_seen++;
                check("exp_avail_chk", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("kind_chk", 32'(e.is_chk), 32'd1);
                    check("chk_num_orig", 32'(num_orig_insts), e.val);
                    check("chk_num_dup", 32'(num_dup_insts), e.val);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input int stall_pct, input int gap_max);
        bit done;
        done     = 1'b0;
        imem_vld = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            pipe_rdy = ($urandom_range(0, 99) >= stall_pct);
            step();
        end
        imem_vld   = 1'b1;
        imem_rdata = ins;
        for (int t = 0; t < 200 && !done; t++) begin
            pipe_rdy = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            check("imem_rdy_orig", 32'(imem_rdy), 32'(pipe_rdy));
            if (imem_rdy) begin
                done = 1'b1;
                exp_q.push_back('{is_chk: 1'b0, val: remap(ins, 1'b0)});
                if (nfields(ins) != 0) mbuf.push_back(remap(ins, 1'b0));
            end
            step();
        end
        imem_vld = 1'b0;
        if (!done) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_dup_expect();
        foreach (mbuf[i]) exp_q.push_back('{is_chk: 1'b0, val: remap(mbuf[i], 1'b1)});
        repeat (DRAIN_CYCLES) exp_q.push_back('{is_chk: 1'b0, val: NOP});
        exp_q.push_back('{is_chk: 1'b1, val: 32'(mbuf.size())});
    endtask

    task automatic trigger(output bit active);
        active   = (mbuf.size() != 0);
        pipe_rdy = 1'b1;
        imem_vld = 1'b0;
        if (mbuf.size() == DEPTH) begin
            push_dup_expect();
            @(negedge clk);
            check("imem_rdy_full", 32'(imem_rdy), 32'd0);
            step();
        end else begin
            exec_dup = 1'b1;
            step();
            exec_dup = 1'b0;
            if (active) push_dup_expect();
            else begin
                @(negedge clk);
                check("empty_dup_ignored", 32'(imem_rdy), 32'd1);
                step();
            end
        end
    endtask

    task automatic close_seq();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mbuf.delete();
    endtask

    task automatic finish_seq(input int stall_pct);
        int seen0;
        seen0 = chk_seen;
        for (int t = 0; t < 400 && chk_seen == seen0; t++) begin
            pipe_rdy   = ($urandom_range(0, 99) >= stall_pct);
            exec_dup   = 1'($urandom_range(0, 1));
            imem_vld   = 1'($urandom_range(0, 1));
            imem_rdata = rand_instr();
            step();
        end
        exec_dup = 1'b0;
        imem_vld = 1'b0;
        if (chk_seen == seen0) check("chk_timeout", 32'd0, 32'd1);
        close_seq();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit act;
        bit found;
        int lat;
        int seen0;

        // Reset held two cycles with a valid fetch offered.
        rst        = 1'b1;
        imem_vld   = 1'b1;
        imem_rdata = 32'h0020_81B3;
        pipe_rdy   = 1'b1;
        exec_dup   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_qed_vld", 32'(qed_vld), 32'd0);
            check("rst_imem_rdy", 32'(imem_rdy), 32'd0);
            check("rst_num_orig", 32'(num_orig_insts), 32'd0);
            check("rst_num_dup", 32'(num_dup_insts), 32'd0);
            check("rst_chk_en", 32'(chk_en), 32'd0);
            check("rst_wtc", 32'(wait_till_commit), 32'd0);
            step();
        end
        rst      = 1'b0;
        imem_vld = 1'b0;
        mon_en   = 1'b1;
        step();

        // ADD x3,x1,x2 then exec_dup; check strobe latency after the duplicate.
        fetch(32'h0020_81B3, 0, 0);
        trigger(act);
        pipe_rdy = 1'b1;
        @(negedge clk);
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            @(negedge clk);
            if (chk_en) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("chk_latency", 32'(lat), 32'(DRAIN_CYCLES + 1));
        step();
        close_seq();

        // ADDI x0,x17,5: rd stays x0 in both forms.
        fetch(32'h0058_8013, 0, 0);
        trigger(act);
        finish_seq(0);

        // Full buffer: eight ADDIs, no exec_dup.
        for (int j = 0; j < DEPTH; j++) begin
            logic [31:0] ins;
            ins      = $urandom;
            ins[6:0] = 7'h13;
            fetch(ins, 0, 0);
        end
        trigger(act);
        finish_seq(0);

        // Stall mid-DUP for three cycles.
        for (int j = 0; j < 4; j++) begin
            logic [31:0] ins;
            ins      = $urandom;
            ins[6:0] = 7'h33;
            fetch(ins, 0, 0);
        end
        trigger(act);
        pipe_rdy = 1'b1;
        step();
        pipe_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("stall_qed_instr", qed_instr, remap(mbuf[1], 1'b1));
            check("stall_num_dup", 32'(num_dup_insts), 32'd1);
            check("stall_qed_vld", 32'(qed_vld), 32'd1);
            step();
        end
        finish_seq(0);

        // Illegal opcode: BEQ becomes NOP and is not counted.
        fetch(32'h0011_0093, 0, 0);
        fetch(32'h0020_8463, 0, 0);
        check("beq_not_counted", 32'(num_orig_insts), 32'd1);
        trigger(act);
        finish_seq(0);

        // exec_dup with an empty buffer is ignored.
        fetch(32'h0020_8463, 0, 0);
        trigger(act);
        check("empty_seq_inactive", 32'(act), 32'd0);
        close_seq();

        // Reset asserted in DRAIN abandons the sequence.
        fetch(32'h0030_0113, 0, 0);
        trigger(act);
        pipe_rdy = 1'b1;
        found    = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (wait_till_commit) found = 1'b1;
            else step();
        end
        check("drain_reached", 32'(found), 32'd1);
        step();
        seen0 = chk_seen;
        rst   = 1'b1;
        @(negedge clk);
        check("rst_drain_wtc", 32'(wait_till_commit), 32'd0);
        check("rst_drain_chk", 32'(chk_en), 32'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        mbuf.delete();
        @(negedge clk);
        check("post_rst_orig", 32'(imem_rdy), 32'd1);
        check("post_rst_wtc", 32'(wait_till_commit), 32'd0);
        check("post_rst_num_orig", 32'(num_orig_insts), 32'd0);
        check("post_rst_num_dup", 32'(num_dup_insts), 32'd0);
        repeat (12) step();
        check("no_chk_after_rst", 32'(chk_seen), 32'(seen0));

        // Randomized sequences with stalls, gaps and mixed opcodes.
        for (int s = 0; s < 25; s++) begin
            int n;
            int sp;
            n  = $urandom_range(1, DEPTH + 3);
            sp = $urandom_range(0, 40);
            for (int j = 0; j < n && mbuf.size() < DEPTH; j++) fetch(rand_instr(), sp, 2);
            trigger(act);
            if (act) finish_seq(sp);
            else close_seq();
        end

        repeat (4) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
